// File: rtl/bpn_pkg.sv
// bpn_pkg: shared types and constants for the back_propper_n neuron unit.
//   fxp_t        signed fixed-point word at the default width (Q16.16)
//   fxp_wide_t   full-width signed product of two fxp_t words
//   bpn_state_e  controller states IDLE / ACCUM / UPDATE / DONE
//   ONE          fixed-point 1.0 at the default format
//   sat()        clamp a (2*WIDTH+1)-bit intermediate into fxp_t
package bpn_pkg;

  localparam int BPN_WIDTH      = 32;
  localparam int BPN_FRAC       = 16;
  localparam int BPN_N_IN       = 4;
  localparam int BPN_LR_SHIFT   = 8;
  localparam int BPN_LEAK_SHIFT = 3;

  typedef logic signed [BPN_WIDTH-1:0]   fxp_t;
  typedef logic signed [2*BPN_WIDTH-1:0] fxp_wide_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } bpn_state_e;

  localparam fxp_t ONE = fxp_t'(1 << BPN_FRAC);

  function automatic fxp_t sat(input logic signed [2*BPN_WIDTH:0] x);
    logic signed [2*BPN_WIDTH:0] max_v;
    logic signed [2*BPN_WIDTH:0] min_v;
    max_v = {{(BPN_WIDTH+2){1'b0}}, {(BPN_WIDTH-1){1'b1}}};
    min_v = {{(BPN_WIDTH+2){1'b1}}, {(BPN_WIDTH-1){1'b0}}};
    if (x > max_v)      sat = max_v[BPN_WIDTH-1:0];
    else if (x < min_v) sat = min_v[BPN_WIDTH-1:0];
    else                sat = x[BPN_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/bpn_if.sv
// bpn_if: bus between the layer controller (master) and back_propper_n (slave).
//   bpn_start  master->slave  start request, element vectors p/w and error bp
//   bpn_busy   slave->master  run in progress
//   bpn_done   slave->master  one-cycle completion pulse
//   bpn_gate, bpn_bpc, bpn_wn  slave->master results
//
// Handshake: bpn_start is a request that is accepted only on a clock edge where
// the unit is idle (bpn_busy low); p, w and bp are captured on that same edge and
// may change afterwards. Requests while busy are dropped, not queued. bpn_done
// pulses once per accepted request; gate/bpc/wn are valid from that pulse until
// the next accepted request.
interface bpn_if #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 32
);
  logic                    bpn_start;
  logic [N_IN*WIDTH-1:0]   bpn_p;
  logic [N_IN*WIDTH-1:0]   bpn_w;
  logic [WIDTH-1:0]        bpn_bp;
  logic                    bpn_busy;
  logic                    bpn_done;
  logic                    bpn_gate;
  logic [N_IN*WIDTH-1:0]   bpn_bpc;
  logic [N_IN*WIDTH-1:0]   bpn_wn;

  modport master (
    output bpn_start, bpn_p, bpn_w, bpn_bp,
    input  bpn_busy, bpn_done, bpn_gate, bpn_bpc, bpn_wn
  );

  modport slave (
    input  bpn_start, bpn_p, bpn_w, bpn_bp,
    output bpn_busy, bpn_done, bpn_gate, bpn_bpc, bpn_wn
  );
endinterface

// File: rtl/fxp_mul_shift.sv
// fxp_mul_shift: signed WIDTH x WIDTH multiplier with optional arithmetic
// right shift by FRAC and a saturated WIDTH-bit view of the result.
//   a_i, b_i    signed operands
//   shift_en_i  1: wide_o = (a*b) >>> FRAC ; 0: wide_o = a*b (full product)
//   wide_o      (2*WIDTH+1)-bit signed result, sign-extended
//   sat_o       wide_o clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]
module fxp_mul_shift #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic                    shift_en_i,
  output logic signed [2*WIDTH:0] wide_o,
  output logic signed [WIDTH-1:0] sat_o
);

  localparam logic signed [2*WIDTH:0] MAX_V = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH:0] MIN_V = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH:0]   prod_ext;

  always_comb begin
    // Operands are sign-extended first so the truncated product is exact.
    a_ext    = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    b_ext    = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    prod     = a_ext * b_ext;
    prod_ext = {prod[2*WIDTH-1], prod};
    wide_o   = shift_en_i ? (prod_ext >>> FRAC) : prod_ext;
    if (wide_o > MAX_V)      sat_o = MAX_V[WIDTH-1:0];
    else if (wide_o < MIN_V) sat_o = MIN_V[WIDTH-1:0];
    else                     sat_o = wide_o[WIDTH-1:0];
  end

endmodule

// File: rtl/back_propper_n.sv
// back_propper_n: sequential backpropagation for one ReLU neuron with N_IN inputs.
// A start latches p, w and bp; ACCUM sums p[i]*w[i] over N_IN cycles and sets the
// ReLU gate; UPDATE writes one bpc/wn element per cycle; DONE ends the run and
// bpn_done pulses on the following cycle.
//   bpn_clk, bpn_rst  clock, synchronous active-high reset
//   bus (bpn_if.slave) start/p/w/bp in; busy/done/gate/bpc/wn out
//   dbg_state          current controller state
// Optional build macro BPN_LEAKY_EN: an inactive gate propagates bp >>> LEAK_SHIFT
// instead of zero (the reported gate is unchanged).
module back_propper_n
  import bpn_pkg::*;
#(
  parameter int WIDTH      = BPN_WIDTH,
  parameter int FRAC       = BPN_FRAC,
  parameter int N_IN       = BPN_N_IN,
  parameter int LR_SHIFT   = BPN_LR_SHIFT,
  parameter int LEAK_SHIFT = BPN_LEAK_SHIFT
) (
  input  logic       bpn_clk,
  input  logic       bpn_rst,
  bpn_if.slave       bus,
  output bpn_state_e dbg_state
);

  localparam int ACC_W = 2*WIDTH + $clog2(N_IN) + 1;
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int VEC_W = N_IN*WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN-1);

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [2*WIDTH:0] x);
    logic signed [2*WIDTH:0] max_v;
    logic signed [2*WIDTH:0] min_v;
    max_v = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    min_v = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
    if (x > max_v)      sat_w = max_v[WIDTH-1:0];
    else if (x < min_v) sat_w = min_v[WIDTH-1:0];
    else                sat_w = x[WIDTH-1:0];
  endfunction

  bpn_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [VEC_W-1:0]        p_q, p_d;
  logic [VEC_W-1:0]        w_q, w_d;
  logic signed [WIDTH-1:0] bp_q, bp_d;
  logic                    gate_q, gate_d;
  logic                    done_q, done_d;
  logic [VEC_W-1:0]        bpc_q, bpc_d;
  logic [VEC_W-1:0]        wn_q, wn_d;

  logic signed [WIDTH-1:0] cur_p, cur_w, delta;
  logic signed [WIDTH-1:0] mul0_a, mul0_b;
  logic                    mul0_shift;
  logic signed [2*WIDTH:0] mul0_wide, mul1_wide;
  logic signed [WIDTH-1:0] mul0_sat, mul1_sat_unused;
  logic signed [2*WIDTH:0] w_ext, lr_term, wn_diff;

  // ---------------- state register ----------------
  always_ff @(posedge bpn_clk) begin
    if (bpn_rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.bpn_start)      state_d = ACCUM;
      ACCUM:   if (idx_q == LAST_IDX)  state_d = UPDATE;
      UPDATE:  if (idx_q == LAST_IDX)  state_d = DONE;
      DONE:                            state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
    // done is registered off DONE so it is seen one cycle after the last write,
    // with every result register already settled.
    done_d = (state_q == DONE);
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.bpn_busy = (state_q != IDLE);
    bus.bpn_done = done_q;
    bus.bpn_gate = gate_q;
    bus.bpn_bpc  = bpc_q;
    bus.bpn_wn   = wn_q;
    dbg_state    = state_q;
  end

  // ---------------- shared multiplier pair ----------------
  always_comb begin
    cur_p = p_q[int'(idx_q)*WIDTH +: WIDTH];
    cur_w = w_q[int'(idx_q)*WIDTH +: WIDTH];
`ifdef BPN_LEAKY_EN
    delta = gate_q ? bp_q : (bp_q >>> LEAK_SHIFT);
`else
    delta = gate_q ? bp_q : '0;
`endif
    // ACCUM reuses multiplier 0 for the unshifted p*w product.
    mul0_shift = (state_q != ACCUM);
    mul0_a     = (state_q == ACCUM) ? cur_p : cur_w;
    mul0_b     = (state_q == ACCUM) ? cur_w : delta;
  end

`ifndef BPN_LEAKY_EN
  // The plain ReLU build has no use for the leak slope.
  localparam int leak_shift_unused = LEAK_SHIFT;
`endif

  fxp_mul_shift #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul0 (
    .a_i        (mul0_a),
    .b_i        (mul0_b),
    .shift_en_i (mul0_shift),
    .wide_o     (mul0_wide),
    .sat_o      (mul0_sat)
  );

  fxp_mul_shift #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul1 (
    .a_i        (cur_p),
    .b_i        (delta),
    .shift_en_i (1'b1),
    .wide_o     (mul1_wide),
    .sat_o      (mul1_sat_unused)
  );

  // ---------------- datapath next values ----------------
  always_comb begin
    p_d    = p_q;
    w_d    = w_q;
    bp_d   = bp_q;
    idx_d  = idx_q;
    acc_d  = acc_q;
    gate_d = gate_q;
    bpc_d  = bpc_q;
    wn_d   = wn_q;

    w_ext   = {{(WIDTH+1){cur_w[WIDTH-1]}}, cur_w};
    lr_term = mul1_wide >>> LR_SHIFT;
    wn_diff = w_ext - lr_term;

    case (state_q)
      IDLE: begin
        if (bus.bpn_start) begin
          p_d   = bus.bpn_p;
          w_d   = bus.bpn_w;
          bp_d  = bus.bpn_bp;
          acc_d = '0;
          idx_d = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_q + ACC_W'(mul0_wide);
        if (idx_q == LAST_IDX) begin
          // Strictly positive only: an exact-zero sum keeps the gate closed.
          gate_d = !acc_d[ACC_W-1] && (acc_d != '0);
          idx_d  = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      UPDATE: begin
        bpc_d[int'(idx_q)*WIDTH +: WIDTH] = mul0_sat;
        wn_d[int'(idx_q)*WIDTH +: WIDTH]  = sat_w(wn_diff);
        if (idx_q == LAST_IDX) idx_d = '0;
        else                   idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge bpn_clk) begin
    if (bpn_rst) begin
      p_q    <= '0;
      w_q    <= '0;
      bp_q   <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
      gate_q <= 1'b0;
      bpc_q  <= '0;
      wn_q   <= '0;
    end else begin
      p_q    <= p_d;
      w_q    <= w_d;
      bp_q   <= bp_d;
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      gate_q <= gate_d;
      bpc_q  <= bpc_d;
      wn_q   <= wn_d;
    end
  end

endmodule

// File: doc/back_propper_n.md
Name: back_propper_n

Overview:
- Sequential, parametrised backpropagation unit for one ReLU neuron with N_IN inputs.
- Latches the inputs, activations and upstream error on start. Accumulates the pre-activation, derives the ReLU gate, then produces per-input backpropagated error and updated weights.
- Sits between the layer error bus and the weight store. Replaces the single-input combinational propagator.

Parameters:
- WIDTH, 32, signed fixed-point word width of p, w, bp, bpc, wn.
- FRAC, 16, fractional bits (Q(WIDTH-FRAC).FRAC).
- N_IN, 4, number of inputs/weights per neuron (>=1).
- LR_SHIFT, 8, learning rate = 2^-LR_SHIFT.
- LEAK_SHIFT, 3, leaky slope = 2^-LEAK_SHIFT (used only with BPN_LEAKY_EN).

Ports:
- bpn_clk  in  1  clock.
- bpn_rst  in  1  synchronous active-high reset.
- bpn_start  in  1  start request, sampled in IDLE only.
- bpn_p  in  N_IN*WIDTH  input activations, element i at [i*WIDTH +: WIDTH].
- bpn_w  in  N_IN*WIDTH  current weights.
- bpn_bp  in  WIDTH  upstream error for this neuron.
- bpn_busy  out  1  high from the cycle after accepted start through DONE.
- bpn_done  out  1  one-cycle pulse; results valid from this cycle until the next accepted start.
- bpn_gate  out  1  ReLU gate of the last run (1 = active).
- bpn_bpc  out  N_IN*WIDTH  backpropagated error per input.
- bpn_wn  out  N_IN*WIDTH  updated weights.

Behaviour:
- Reset: state IDLE, index 0, accumulator 0; busy=0, done=0, gate=0, bpc=0, wn=0.
- Reset mid-operation aborts the run: next cycle matches reset, and no done is issued.
- IDLE: on start=1, latch p, w, bp; clear accumulator and index; go to ACCUM. Start in any other state is ignored.
- ACCUM (N_IN cycles): each cycle adds p[idx]*w[idx] (full 2*WIDTH signed product) into an accumulator of 2*WIDTH+$clog2(N_IN)+1 bits. At idx==N_IN-1 set gate = (acc > 0), reset idx, go to UPDATE. Exactly zero gives gate 0.
- UPDATE (N_IN cycles): each cycle writes element idx:
  - delta = gate ? bp : 0
  - bpc[idx] = sat((w[idx]*delta) >>> FRAC)
  - wn[idx] = sat(w[idx] - (((p[idx]*delta) >>> FRAC) >>> LR_SHIFT))
  - At idx==N_IN-1 go to DONE.
- DONE (1 cycle): done=1, then IDLE.
- Latency: done asserts 2*N_IN+2 cycles after the start cycle (start at cycle 0 gives done at cycle 10 for N_IN=4).
- Arithmetic:
  - All shifts are arithmetic (floor rounding).
  - Intermediates are computed at 2*WIDTH+1 bits.
  - sat() clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Output registers hold their value between runs. Elements not yet written in UPDATE keep prior-run values.
- One multiplier pair is shared across elements; no per-element combinational multipliers.

Optional Feature:
- Macro BPN_LEAKY_EN.
- Defined: inactive gate gives delta = bp >>> LEAK_SHIFT instead of 0. bpn_gate is still (acc > 0).
- Undefined: plain ReLU as above; LEAK_SHIFT unused.

Decomposition:
- Package bpn_pkg: fxp_t (signed WIDTH), wide product type, state enum {IDLE, ACCUM, UPDATE, DONE}, sat function, ONE constant = 1<<FRAC.
- One sub-module, fxp_mul_shift: signed multiply then arithmetic shift by FRAC, with optional saturation. Instanced twice (w*delta and p*delta; also p*w in ACCUM).

Test Plan:
(Defaults; 1.0 = 0x00010000.)
- p=1.0 x4, w=0.5 (0x8000) x4, bp=1.0, start -> gate=1, done at cycle 10, bpc=0x00008000 x4, wn=0x00007F00 x4.
- Same but w=-0.5 (0xFFFF8000) -> acc=-2.0, gate=0, bpc=0 x4, wn=0xFFFF8000 x4.
- p=1.0 x4, w={0.5,-0.5,0.5,-0.5} -> acc=0, gate=0, wn=w, bpc=0.
- Overflow clamp:
  - Stimulus: p0=-1.0, w0=0x7FFFFF00, p1=w1=200.0, others 0, bp=256.0 (0x01000000).
  - Response: gate=1; wn0 = 0x7FFFFFFF (saturated); wn1 = 200.0 - 200.0 = 0; bpc0 saturates to 0x7FFFFFFF.
- Abort and ignored start: assert rst in the 2nd ACCUM cycle -> next cycle busy=0, outputs 0, no done pulse. Restart vector 1 -> correct results at cycle 10. Start pulses during ACCUM/UPDATE/DONE are ignored, and only one done is produced.
- BPN_LEAKY_EN defined, vector 2 -> delta=bp>>>3=0x2000. bpc=0xFFFFF000 x4. wn = 0xFFFF8000 - (0x2000>>>8 = 0x20) = 0xFFFF7FE0 x4.
